i2c_slave_responder: RTL and testbench



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 53 +++++
 rtl/i2c_slave_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and byte length.
// Used by the slave responder and by the APB-to-I2C bridge master.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes the asynchronous SCL/SDA pin levels into the PCLK domain and flags bus events.
// Ports:
//   PCLK, PRESETn       clock and synchronous active-low reset
//   scl_i, sda_i        raw pin levels
//   scl_s, sda_s        synchronized levels
//   scl_rise, scl_fall  one-cycle SCL edge flags
//   start_det           SDA fell while SCL stayed high
//   stop_det            SDA rose while SCL stayed high
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_d_q;
  logic                   sda_d_q;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d_q    <= scl_sync_q[SYNC_STAGES-1];
      sda_d_q    <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d_q;
  assign scl_fall  = ~scl_s & scl_d_q;
  // SCL must be high both before and after the SDA transition.
  assign start_det = scl_s & scl_d_q & sda_d_q & ~sda_s;
  assign stop_det  = scl_s & scl_d_q & ~sda_d_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: detects START/STOP, matches a 7-bit address, ACKs it, delivers write bytes to
// the fabric and fetches read bytes from it. No clock stretching.
// Ports:
//   PCLK, PRESETn  clock and synchronous active-low reset
//   scl_i, sda_i   asynchronous bus pin levels
//   sda_oe         1 pulls SDA low (open drain)
//   tx_data        next read byte, captured when tx_load pulses
//   tx_load        one-cycle pulse: tx_data captured
//   rx_data        last received write byte
//   rx_valid       one-cycle pulse: rx_data updated
//   addr_hit       high from address ACK until STOP or repeated START
//   busy           high between START and STOP
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);

  localparam logic [3:0] ByteBits = 4'(BITS_PER_BYTE);
  localparam logic [3:0] LastBit  = 4'(BITS_PER_BYTE - 1);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic unused_scl_s;

  i2c_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign unused_scl_s = scl_s;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       addr_hit_q, addr_hit_d;
  logic       busy_q, busy_d;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    addr_hit_d = addr_hit_q;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      state_d    = StAddr;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
              rw_d      = sda_s;
              // shift_q[6:0] already holds address bits [7:1] of the byte.
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_d    = StAddrAck;
                addr_hit_d = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // First SCL fall drives the ACK, the second ends the ACK clock.
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end else begin
              tx_load_d = 1'b1;
              shift_d   = {tx_data[6:0], 1'b0};
              sda_oe_d  = ~tx_data[7];
              state_d   = StRdData;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == LastBit) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = StWrAck;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end
          end
        end
        // Bit 7 is already on the bus at entry; falls after rises 1..7 drive bits 6..0.
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == ByteBits) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdAck;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        // bit_cnt_q == 1 records that the master ACKed on this clock.
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              bit_cnt_d = '0;
              state_d   = StIgnore;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            tx_load_d = 1'b1;
            shift_d   = {tx_data[6:0], 1'b0};
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = '0;
            state_d   = StRdData;
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged master drives SCL/SDA, the bus is
// wired-AND with the slave's open-drain pull.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       busy;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rx_log[$];
  int         tx_loads = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 PCLK = ~PCLK;

  i2c_slave_responder #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .addr_hit(addr_hit),
    .busy    (busy)
  );

  always @(negedge PCLK) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_load) tx_loads++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_log.size()) ? rx_log[i] : 8'hxx;
  endfunction

  // One SCL clock: SDA set mid-low, bus sampled mid-high.
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    cyc(4);
    scl_m = 1'b1;
    cyc(4);
    r = sda_line;
    cyc(4);
    scl_m = 1'b0;
    cyc(4);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    cyc(4);
    scl_m = 1'b1;
    cyc(6);
    sda_m = 1'b0;
    cyc(6);
    scl_m = 1'b0;
    cyc(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    cyc(4);
    scl_m = 1'b1;
    cyc(6);
    sda_m = 1'b1;
    cyc(6);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;

    // Reset state
    cyc(3);
    chk("rst sda_oe", 32'(sda_oe), 32'd0);
    chk("rst tx_load", 32'(tx_load), 32'd0);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst rx_data", 32'(rx_data), 32'h00);
    chk("rst addr_hit", 32'(addr_hit), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst state", 32'(dut.state_q), 32'(StIdle));
    PRESETn = 1'b1;
    cyc(3);

    // Write 0x3C, 0xC3 to 0x50
    start_c();
    chk("t1 busy", 32'(busy), 32'd1);
    wr_byte(8'hA0, ack);
    chk("t1 addr ack", 32'(ack), 32'd0);
    chk("t1 addr_hit", 32'(addr_hit), 32'd1);
    wr_byte(8'h3C, ack);
    chk("t1 data0 ack", 32'(ack), 32'd0);
    wr_byte(8'hC3, ack);
    chk("t1 data1 ack", 32'(ack), 32'd0);
    stop_c();
    cyc(2);
    chk("t1 busy after stop", 32'(busy), 32'd0);
    chk("t1 addr_hit after stop", 32'(addr_hit), 32'd0);
    chk("t1 rx count", 32'(rx_log.size()), 32'd2);
    chk("t1 rx0", 32'(rx_at(0)), 32'h3C);
    chk("t1 rx1", 32'(rx_at(1)), 32'hC3);
    rx_log.delete();

    // Wrong address 0x51
    start_c();
    wr_byte(8'hA2, ack);
    chk("t2 addr nack", 32'(ack), 32'd1);
    chk("t2 addr_hit", 32'(addr_hit), 32'd0);
    chk("t2 busy", 32'(busy), 32'd1);
    wr_byte(8'h55, ack);
    chk("t2 data nack", 32'(ack), 32'd1);
    stop_c();
    cyc(2);
    chk("t2 rx count", 32'(rx_log.size()), 32'd0);
    chk("t2 busy after stop", 32'(busy), 32'd0);

    // Read two bytes, ACK then NACK
    tx_loads = 0;
    tx_data  = 8'h96;
    start_c();
    wr_byte(8'hA1, ack);
    chk("t3 addr ack", 32'(ack), 32'd0);
    chk("t3 tx_load first", 32'(tx_loads), 32'd1);
    tx_data = 8'h5A;
    rd_byte(1'b0, d);
    chk("t3 rd0", 32'(d), 32'h96);
    chk("t3 tx_load second", 32'(tx_loads), 32'd2);
    rd_byte(1'b1, d);
    chk("t3 rd1", 32'(d), 32'h5A);
    chk("t3 sda released", 32'(sda_oe), 32'd0);
    chk("t3 state ignore", 32'(dut.state_q), 32'(StIgnore));
    chk("t3 tx_load total", 32'(tx_loads), 32'd2);
    stop_c();
    cyc(2);
    chk("t3 busy after stop", 32'(busy), 32'd0);

    // Write, repeated START, read
    start_c();
    wr_byte(8'hA0, ack);
    chk("t4 addr ack", 32'(ack), 32'd0);
    wr_byte(8'h11, ack);
    chk("t4 data ack", 32'(ack), 32'd0);
    chk("t4 addr_hit before rs", 32'(addr_hit), 32'd1);
    start_c();
    chk("t4 addr_hit after rs", 32'(addr_hit), 32'd0);
    chk("t4 busy after rs", 32'(busy), 32'd1);
    tx_data = 8'hE7;
    wr_byte(8'hA1, ack);
    chk("t4 rd addr ack", 32'(ack), 32'd0);
    chk("t4 addr_hit reasserted", 32'(addr_hit), 32'd1);
    rd_byte(1'b1, d);
    chk("t4 rd", 32'(d), 32'hE7);
    stop_c();
    cyc(2);
    chk("t4 rx count", 32'(rx_log.size()), 32'd1);
    chk("t4 rx0", 32'(rx_at(0)), 32'h11);
    rx_log.delete();

    // STOP after a partial data byte
    start_c();
    wr_byte(8'hA0, ack);
    chk("t5 addr ack", 32'(ack), 32'd0);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    stop_c();
    cyc(2);
    chk("t5 rx count", 32'(rx_log.size()), 32'd0);
    chk("t5 state idle", 32'(dut.state_q), 32'(StIdle));
    chk("t5 sda_oe", 32'(sda_oe), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);

    // Reset in the middle of the address ACK
    tx_loads = 0;
    start_c();
    for (int i = 7; i >= 0; i--) bit_io(((8'hA0 >> i) & 8'h01) != 8'h00, r);
    sda_m = 1'b1;
    cyc(4);
    chk("t6 ack driven", 32'(sda_oe), 32'd1);
    PRESETn = 1'b0;
    cyc(1);
    chk("t6 rst sda_oe", 32'(sda_oe), 32'd0);
    chk("t6 rst addr_hit", 32'(addr_hit), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst rx_data", 32'(rx_data), 32'h00);
    cyc(1);
    PRESETn = 1'b1;
    cyc(2);
    chk("t6 state idle", 32'(dut.state_q), 32'(StIdle));
    wr_byte(8'hA0, ack);
    chk("t6 no ack without start", 32'(ack), 32'd1);
    chk("t6 addr_hit", 32'(addr_hit), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 rx count", 32'(rx_log.size()), 32'd0);
    chk("t6 tx_load count", 32'(tx_loads), 32'd0);
    stop_c();
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
